// File: rtl/spi_flash_cmd_engine.sv
// SPI mode-0 command engine for W25Qxx-class serial flash.
// Sends opcode / address / dummy, then streams rd_len received bytes.
module spi_flash_cmd_engine #(
    parameter int CLK_DIV_HALF = 32,
    parameter int LEN_W        = 8
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             start,
    input  logic [7:0]       opcode,
    input  logic [23:0]      addr,
    input  logic             addr_en,
    input  logic             dummy_en,
    input  logic [LEN_W-1:0] rd_len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             flash_cs_n,
    output logic             flash_clk,
    output logic             flash_mosi,
    input  logic             flash_miso
);

    localparam int CW = $clog2(2 * CLK_DIV_HALF) + 1;
    localparam logic [CW-1:0] H_M1  = CW'(CLK_DIV_HALF - 1);
    localparam logic [CW-1:0] H2_M1 = CW'(2 * CLK_DIV_HALF - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_READ,
        S_HOLD,
        S_DESEL
    } state_t;

    state_t           state_q, state_d, nxt;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sclk_q, sclk_d;
    logic [2:0]       bit_q, bit_d;
    logic [1:0]       abyte_q, abyte_d;
    logic [LEN_W-1:0] byte_q, byte_d;
    logic [31:0]      sh_q, sh_d;
    logic [7:0]       rx_q, rx_d;
    logic             addr_en_q, addr_en_d;
    logic             dummy_en_q, dummy_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             cs_n_q, cs_n_d;
    logic             mosi_q, mosi_d;
    logic             bit_end;
    state_t           after_addr, after_dummy;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            sclk_q     <= 1'b0;
            bit_q      <= '0;
            abyte_q    <= '0;
            byte_q     <= '0;
            sh_q       <= '0;
            rx_q       <= '0;
            addr_en_q  <= 1'b0;
            dummy_en_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            cs_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sclk_q     <= sclk_d;
            bit_q      <= bit_d;
            abyte_q    <= abyte_d;
            byte_q     <= byte_d;
            sh_q       <= sh_d;
            rx_q       <= rx_d;
            addr_en_q  <= addr_en_d;
            dummy_en_q <= dummy_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            cs_n_q     <= cs_n_d;
            mosi_q     <= mosi_d;
        end
    end

    // A bit ends on the sys_clk edge that drives flash_clk low.
    assign bit_end     = sclk_q && (cnt_q == H_M1);
    assign after_dummy = (byte_q != '0) ? S_READ : S_HOLD;
    assign after_addr  = dummy_en_q ? S_DUMMY : after_dummy;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sclk_d     = sclk_q;
        bit_d      = bit_q;
        abyte_d    = abyte_q;
        byte_d     = byte_q;
        sh_d       = sh_q;
        rx_d       = rx_q;
        addr_en_d  = addr_en_q;
        dummy_en_d = dummy_en_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        cs_n_d     = cs_n_q;
        mosi_d     = mosi_q;
        nxt        = state_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !done_q) begin
                    state_d    = S_CMD;
                    busy_d     = 1'b1;
                    cs_n_d     = 1'b0;
                    sclk_d     = 1'b0;
                    cnt_d      = '0;
                    bit_d      = '0;
                    abyte_d    = '0;
                    byte_d     = rd_len;
                    sh_d       = {opcode, addr};
                    rx_d       = '0;
                    mosi_d     = opcode[7];
                    addr_en_d  = addr_en;
                    dummy_en_d = dummy_en;
                end
            end
            S_CMD, S_ADDR, S_DUMMY, S_READ: begin
                if (cnt_q == H_M1) begin
                    cnt_d  = '0;
                    sclk_d = !sclk_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    sh_d  = {sh_q[30:0], 1'b0};
                    if (state_q == S_READ) begin
                        rx_d = {rx_q[6:0], flash_miso};
                    end
                    if (bit_q == 3'd7) begin
                        unique case (state_q)
                            S_CMD:   nxt = addr_en_q ? S_ADDR : after_addr;
                            S_ADDR: begin
                                if (abyte_q == 2'd2) begin
                                    nxt = after_addr;
                                end else begin
                                    abyte_d = abyte_q + 2'd1;
                                end
                            end
                            S_DUMMY: nxt = after_dummy;
                            S_READ: begin
                                rd_data_d  = {rx_q[6:0], flash_miso};
                                rd_valid_d = 1'b1;
                                byte_d     = byte_q - LEN_W'(1);
                                nxt = (byte_q == LEN_W'(1)) ? S_HOLD : S_READ;
                            end
                            default: ;
                        endcase
                    end
                    state_d = nxt;
                    mosi_d  = (nxt == S_CMD || nxt == S_ADDR) ? sh_q[30] : 1'b0;
                end
            end
            S_HOLD: begin
                if (cnt_q == H_M1) begin
                    cnt_d   = '0;
                    cs_n_d  = 1'b1;
                    state_d = S_DESEL;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DESEL: begin
                if (cnt_q == H2_M1) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign flash_cs_n = cs_n_q;
    assign flash_clk  = sclk_q;
    assign flash_mosi = mosi_q;

endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
// Bench for spi_flash_cmd_engine: Winbond-style flash model,
// directed table, reset/abort sequence and randomized commands.
module tb_spi_flash_cmd_engine;

    localparam int H = 4;
    localparam int LW = 8;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    opcode = '0;
    logic [23:0]   addr = '0;
    logic          addr_en = 1'b0;
    logic          dummy_en = 1'b0;
    logic [LW-1:0] rd_len = '0;
    logic          busy, done, rd_valid;
    logic [7:0]    rd_data;
    logic          flash_cs_n, flash_clk, flash_mosi;
    logic          flash_miso = 1'b0;

    spi_flash_cmd_engine #(.CLK_DIV_HALF(H), .LEN_W(LW)) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .start(start),
        .opcode(opcode),
        .addr(addr),
        .addr_en(addr_en),
        .dummy_en(dummy_en),
        .rd_len(rd_len),
        .busy(busy),
        .done(done),
        .rd_data(rd_data),
        .rd_valid(rd_valid),
        .flash_cs_n(flash_cs_n),
        .flash_clk(flash_clk),
        .flash_mosi(flash_mosi),
        .flash_miso(flash_miso)
    );

    always #5 sys_clk = ~sys_clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // memory image and ID bytes of the modelled flash
    function automatic logic [7:0] mem_byte(input logic [23:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [7:0] op,
                                            input logic [23:0] a,
                                            input int i);
        logic [23:0] ai;
        ai = a + 24'(i);
        case (op)
            8'h9F: begin
                case (i % 3)
                    0: return 8'hEF;
                    1: return 8'h40;
                    default: return 8'h18;
                endcase
            end
            8'h90: return ((a[0] ^ i[0]) != 1'b0) ? 8'h14 : 8'hEF;
            default: return mem_byte(ai);
        endcase
    endfunction

    // flash model: samples MOSI on rising, shifts MISO on falling clk
    int          fl_cnt = 0;
    logic [7:0]  fl_op = '0;
    logic [23:0] fl_addr = '0;

    function automatic logic fl_bit(input logic [7:0] op,
                                    input logic [23:0] a, input int c);
        int st;
        int k;
        logic [7:0] b;
        st = (op == 8'h9F) ? 8 : (op == 8'h0B) ? 40 : 32;
        if (c < st) return 1'b0;
        k = c - st;
        b = ref_byte(op, a, k / 8);
        return b[7 - (k % 8)];
    endfunction

    always @(posedge flash_clk or posedge flash_cs_n) begin
        if (flash_cs_n) begin
            fl_cnt <= 0;
        end else begin
            fl_cnt <= fl_cnt + 1;
            if (fl_cnt < 8) fl_op <= {fl_op[6:0], flash_mosi};
            else if (fl_cnt < 32) fl_addr <= {fl_addr[22:0], flash_mosi};
        end
    end

    always @(negedge flash_clk or posedge flash_cs_n) begin
        if (flash_cs_n) flash_miso <= 1'b0;
        else flash_miso <= fl_bit(fl_op, fl_addr, fl_cnt);
    end

    // monitors
    logic [7:0] q_bytes[$];
    int         q_vcyc[$];
    int         q_dcyc[$];
    int         q_csr[$];
    logic       q_mosi[$];
    int         rises = 0;
    int         bad_clk = 0;
    int         cs_low = 0;
    logic       cs_prev = 1'b1;

    always @(negedge sys_clk) begin
        if (rd_valid) begin
            q_bytes.push_back(rd_data);
            q_vcyc.push_back(cyc);
        end
        if (done) q_dcyc.push_back(cyc);
        if (!flash_cs_n) cs_low <= cs_low + 1;
        if (flash_cs_n && !cs_prev) q_csr.push_back(cyc);
        cs_prev <= flash_cs_n;
    end

    always @(posedge flash_clk) begin
        rises <= rises + 1;
        q_mosi.push_back(flash_mosi);
        if (flash_cs_n) bad_clk <= bad_clk + 1;
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    logic [7:0] exp_q[$];

    task automatic run_txn(input logic [7:0] op, input logic [23:0] a,
                           input logic aen, input logic den, input int len,
                           input int expn, input int xs);
        int b0, v0, d0, c0, r0, m0, l0, bad0, t0, lim, bm, mm;
        logic eb;
        b0 = q_bytes.size();
        v0 = q_vcyc.size();
        d0 = q_dcyc.size();
        c0 = q_csr.size();
        m0 = q_mosi.size();
        r0 = rises;
        l0 = cs_low;
        bad0 = bad_clk;
        @(negedge sys_clk);
        opcode = op;
        addr = a;
        addr_en = aen;
        dummy_en = den;
        rd_len = LW'(len);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        t0 = cyc;
        chk("t0_busy", busy, 1);
        chk("t0_cs_n", flash_cs_n, 0);
        chk("t0_clk", flash_clk, 0);
        chk("t0_mosi", flash_mosi, op[7]);
        opcode = 8'($urandom);
        addr = 24'($urandom);
        addr_en = ~aen;
        dummy_en = ~den;
        rd_len = LW'($urandom);
        lim = 2 * H * expn + 3 * H + 50;
        for (int k = 0; k < lim && q_dcyc.size() == d0; k++) begin
            start = (k == xs);
            @(negedge sys_clk);
        end
        start = 1'b0;
        chk("done_seen", q_dcyc.size() > d0, 1);
        repeat (4 * H) @(negedge sys_clk);
        chk("done_count", q_dcyc.size() - d0, 1);
        chk("busy_after", busy, 0);
        chk("done_cycle", (q_dcyc.size() > d0) ? q_dcyc[d0] - t0 : -1,
            2 * H * expn + 3 * H);
        chk("cs_rise_cycle", (q_csr.size() > c0) ? q_csr[c0] - t0 : -1,
            2 * H * expn + H);
        chk("cs_low_cycles", cs_low - l0, 2 * H * expn + H);
        chk("rising_edges", rises - r0, expn);
        chk("clk_outside_cs", bad_clk - bad0, 0);
        mm = 0;
        for (int i = 0; i < expn && m0 + i < q_mosi.size(); i++) begin
            if (i < 8) eb = op[7 - i];
            else if (aen && i < 32) eb = a[23 - (i - 8)];
            else eb = 1'b0;
            if (q_mosi[m0 + i] !== eb) mm++;
        end
        chk("mosi_bits_bad", mm, 0);
        chk("byte_count", q_bytes.size() - b0, len);
        bm = 0;
        for (int i = 0; i < len && i < exp_q.size() && b0 + i < q_bytes.size(); i++)
            if (q_bytes[b0 + i] !== exp_q[i]) begin
                bm++;
                $display("FAIL rd_data[%0d]: got 0x%0h expected 0x%0h",
                         i, q_bytes[b0 + i], exp_q[i]);
            end
        chk("rd_data_bad", bm, 0);
        if (len > 0)
            chk("first_valid_cycle", (q_vcyc.size() > v0) ? q_vcyc[v0] - t0 : -1,
                2 * H * (expn - 8 * len + 8));
    endtask

    typedef struct {
        logic [7:0]  op;
        logic [23:0] a;
        logic        aen;
        logic        den;
        int          len;
        int          expn;
        logic [31:0] bytes;
        int          xs;
    } vec_t;

    vec_t vt[6];

    initial begin
        int b0, d0, sel, len, expn;
        logic [7:0] op;
        logic [23:0] a;
        logic aen, den;

        vt[0] = '{8'h90, 24'h000000, 1'b1, 1'b0, 2, 48, 32'hEF14_0000, -1};
        vt[1] = '{8'h9F, 24'h000000, 1'b0, 1'b0, 3, 32, 32'hEF40_1800, -1};
        vt[2] = '{8'h06, 24'h000000, 1'b0, 1'b0, 0, 8, 32'h0, -1};
        vt[3] = '{8'h0B, 24'h000100, 1'b1, 1'b1, 4, 72, 32'hA4A5_A6A7, -1};
        vt[4] = '{8'h90, 24'h000000, 1'b1, 1'b0, 2, 48, 32'hEF14_0000, 100};
        vt[5] = '{8'h9F, 24'h000000, 1'b0, 1'b0, 3, 32, 32'hEF40_1800, -1};

        repeat (3) @(negedge sys_clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_cs_n", flash_cs_n, 1);
        chk("rst_clk", flash_clk, 0);
        chk("rst_mosi", flash_mosi, 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int t = 0; t < 6; t++) begin
            exp_q.delete();
            for (int i = 0; i < vt[t].len; i++)
                exp_q.push_back(vt[t].bytes[31 - 8 * i -: 8]);
            run_txn(vt[t].op, vt[t].a, vt[t].aen, vt[t].den,
                    vt[t].len, vt[t].expn, vt[t].xs);
        end

        // reset asserted in the middle of the address phase
        b0 = q_bytes.size();
        d0 = q_dcyc.size();
        @(negedge sys_clk);
        opcode = 8'h03;
        addr = 24'h000123;
        addr_en = 1'b1;
        dummy_en = 1'b0;
        rd_len = 8'd2;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (2 * H * 18) @(negedge sys_clk);
        chk("pre_abort_cs_n", flash_cs_n, 0);
        sys_rst_n = 1'b0;
        #1;
        chk("abort_cs_n", flash_cs_n, 1);
        chk("abort_clk", flash_clk, 0);
        chk("abort_busy", busy, 0);
        chk("abort_mosi", flash_mosi, 0);
        repeat (3) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (20 * H) @(negedge sys_clk);
        chk("abort_no_valid", q_bytes.size() - b0, 0);
        chk("abort_no_done", q_dcyc.size() - d0, 0);
        exp_q.delete();
        exp_q.push_back(mem_byte(24'h000123));
        exp_q.push_back(mem_byte(24'h000124));
        run_txn(8'h03, 24'h000123, 1'b1, 1'b0, 2, 48, -1);

        // randomized well-formed read commands against the reference model
        for (int r = 0; r < 8; r++) begin
            sel = $urandom_range(0, 2);
            a = 24'($urandom);
            case (sel)
                0: begin op = 8'h03; aen = 1'b1; den = 1'b0; len = $urandom_range(0, 5); end
                1: begin op = 8'h0B; aen = 1'b1; den = 1'b1; len = $urandom_range(0, 5); end
                default: begin op = 8'h9F; aen = 1'b0; den = 1'b0; len = $urandom_range(0, 3); end
            endcase
            expn = 8 + (aen ? 24 : 0) + (den ? 8 : 0) + 8 * len;
            exp_q.delete();
            for (int i = 0; i < len; i++) exp_q.push_back(ref_byte(op, a, i));
            run_txn(op, a, aen, den, len, expn, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
